// File: rtl/csr_issue_pkg.sv
// csr_issue_pkg: shared types and constants for the CSR issue scheduler.
package csr_issue_pkg;

  localparam int unsigned DefInstW = 113;
  localparam int unsigned DefDepth = 16;
  localparam int unsigned DefPtrW  = 5;
  localparam int unsigned DefOpndW = 32;

  // Window entry field positions.
  localparam int unsigned USE_IMM_BIT = 112;
  localparam int unsigned DEP_MSB     = 111;
  localparam int unsigned DEP_LSB     = 108;
  localparam logic [3:0]  DEP_BYPASS  = 4'hF;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StOpndReq,
    StOpndWait,
    StIssue,
    StWaitWb
  } csr_state_e;

endpackage

// File: rtl/gray_rd_ptr.sv
// gray_rd_ptr: binary read pointer with Gray view, compared against the
// producer's Gray-coded write pointer to derive window emptiness.
module gray_rd_ptr #(
  parameter int unsigned PtrW = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            adv_i,
  input  logic [PtrW-1:0] wr_gray_i,
  output logic [PtrW-2:0] rd_addr_o,
  output logic            empty_o
);

  logic [PtrW-1:0] rd_bin_q;
  logic [PtrW-1:0] rd_gray;

  // Advance by one on each retired CSR; wraps naturally at 2**PtrW.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_bin_q <= '0;
    end else if (adv_i) begin
      rd_bin_q <= rd_bin_q + PtrW'(1);
    end
  end

  // Gray view of the read pointer and emptiness compare.
  always_comb begin
    rd_gray   = rd_bin_q ^ (rd_bin_q >> 1);
    rd_addr_o = rd_bin_q[PtrW-2:0];
    empty_o   = (rd_gray == wr_gray_i);
  end

endmodule

// File: rtl/csr_issue_sched.sv
// csr_issue_sched: in-order, fully serialised CSR issue slot. Fetches the head
// window entry, resolves its operand (immediate, GRF or bypass), issues it and
// waits for writeback before moving to the next entry.
// Optional: define CSR_ISSUE_WB_TIMEOUT_EN to add o_WbTimeout_1, a sticky flag
// raised when writeback takes too long.
module csr_issue_sched
  import csr_issue_pkg::*;
#(
  parameter int unsigned INST_W = DefInstW,
  parameter int unsigned DEPTH  = DefDepth,
  parameter int unsigned PTR_W  = DefPtrW,
  parameter int unsigned OPND_W = DefOpndW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [PTR_W-1:0]          i_CSRCount_5,
  input  logic [DEPTH*INST_W-1:0]   i_InstructionToCsrIssue_1808,
  input  logic [OPND_W-1:0]         i_OperandFromGrf_32,
  output logic                      o_DriveCsrIssueToBypassFifo,
  input  logic                      i_FreeBypassFifoToCsrIssue,
  input  logic                      i_DriveBypassFifoToCsrIssue,
  input  logic [OPND_W-1:0]         i_OperandFromBypassBuffer_32,
  output logic                      o_FreeCsrIssueToBypassBuffer,
  output logic                      o_DriveToExe_1,
  input  logic                      i_FreeToCsrFifo_1,
  output logic [INST_W+OPND_W-1:0]  o_InstructionToExe_145,
  input  logic                      i_DriveFromWriteBack_1,
  output logic                      o_FreeToWriteBack_1,
  output logic                      o_empty_1,
  output logic                      o_IsFirst_1
`ifdef CSR_ISSUE_WB_TIMEOUT_EN
  ,
  output logic                      o_WbTimeout_1
`endif
);

  csr_state_e        state_q;
  logic [INST_W-1:0] inst_q;
  logic [INST_W-1:0] head_entry;
  logic [OPND_W-1:0] opnd_q;
  logic              byp_req_q, byp_rdy_q, exe_vld_q, wb_rdy_q, is_first_q;
  logic [PTR_W-2:0]  rd_addr;
  logic              empty;
  logic              wb_fire;

  assign wb_fire    = wb_rdy_q & i_DriveFromWriteBack_1;
  assign head_entry = i_InstructionToCsrIssue_1808[rd_addr*INST_W +: INST_W];

  gray_rd_ptr #(
    .PtrW(PTR_W)
  ) u_rd_ptr (
    .clk_i    (clk),
    .rst_i    (rst),
    .adv_i    (wb_fire),
    .wr_gray_i(i_CSRCount_5),
    .rd_addr_o(rd_addr),
    .empty_o  (empty)
  );

  // Issue FSM; every handshake output is registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      inst_q     <= '0;
      opnd_q     <= '0;
      byp_req_q  <= 1'b0;
      byp_rdy_q  <= 1'b0;
      exe_vld_q  <= 1'b0;
      wb_rdy_q   <= 1'b0;
      is_first_q <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!empty) begin
            state_q    <= StFetch;
            is_first_q <= 1'b0;
          end
        end
        StFetch: begin
          inst_q <= head_entry;
          if (head_entry[USE_IMM_BIT]) begin
            opnd_q    <= head_entry[OPND_W-1:0];
            exe_vld_q <= 1'b1;
            state_q   <= StIssue;
          end else if (head_entry[DEP_MSB:DEP_LSB] != DEP_BYPASS) begin
            opnd_q    <= i_OperandFromGrf_32;
            exe_vld_q <= 1'b1;
            state_q   <= StIssue;
          end else begin
            byp_req_q <= 1'b1;
            state_q   <= StOpndReq;
          end
        end
        StOpndReq: begin
          if (i_FreeBypassFifoToCsrIssue) begin
            byp_req_q <= 1'b0;
            byp_rdy_q <= 1'b1;
            state_q   <= StOpndWait;
          end
        end
        StOpndWait: begin
          if (i_DriveBypassFifoToCsrIssue) begin
            opnd_q    <= i_OperandFromBypassBuffer_32;
            byp_rdy_q <= 1'b0;
            exe_vld_q <= 1'b1;
            state_q   <= StIssue;
          end
        end
        StIssue: begin
          if (i_FreeToCsrFifo_1) begin
            exe_vld_q <= 1'b0;
            wb_rdy_q  <= 1'b1;
            state_q   <= StWaitWb;
          end
        end
        StWaitWb: begin
          if (i_DriveFromWriteBack_1) begin
            wb_rdy_q   <= 1'b0;
            is_first_q <= 1'b1;
            state_q    <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign o_DriveCsrIssueToBypassFifo  = byp_req_q;
  assign o_FreeCsrIssueToBypassBuffer = byp_rdy_q;
  assign o_DriveToExe_1               = exe_vld_q;
  assign o_FreeToWriteBack_1          = wb_rdy_q;
  assign o_IsFirst_1                  = is_first_q;
  assign o_empty_1                    = empty;
  assign o_InstructionToExe_145       = {inst_q, opnd_q};

`ifdef CSR_ISSUE_WB_TIMEOUT_EN
  logic [7:0] wb_cnt_q;
  logic       wb_timeout_q;
  logic       issue_fire;

  assign issue_fire = exe_vld_q & i_FreeToCsrFifo_1;

  // Count writeback wait cycles; the flag stays set until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_cnt_q     <= '0;
      wb_timeout_q <= 1'b0;
    end else if (issue_fire) begin
      wb_cnt_q <= '0;
    end else if (wb_rdy_q && !i_DriveFromWriteBack_1) begin
      if (wb_cnt_q == 8'hFF) begin
        wb_timeout_q <= 1'b1;
      end else begin
        wb_cnt_q <= wb_cnt_q + 8'd1;
      end
    end
  end

  assign o_WbTimeout_1 = wb_timeout_q;
`endif

endmodule
